// File: rtl/move_code_encoder.sv
// Move-entry front end: synchronizes and debounces the ENTER button, captures the
// switch selection on each press, queues moves and streams them as face/turn code tokens.
module move_code_encoder #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic [4:0]                  SW,
   input  logic                        KEY_enter,
   output logic [3:0]                  code_out,
   output logic                        code_valid,
   input  logic                        code_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        err_illegal,
   output logic                        err_overflow
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PTR_W:0]   DEPTH_V  = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FACE, S_MOD} state_t;

   logic             key_s1_q, key_s2_q;
   logic [4:0]       sw_s1_q, sw_s2_q;
   logic             deb_q;
   logic [CNT_W-1:0] deb_cnt_q;
   logic             press_w, legal_w, full_w, push_w, pop_w;
   logic [4:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   cnt_q;
   logic [4:0]       hold_q, hold_d;
   state_t           state_q, state_d;
   logic             err_illegal_q, err_overflow_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         key_s1_q <= 1'b1;
         key_s2_q <= 1'b1;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         key_s1_q <= KEY_enter;
         key_s2_q <= key_s1_q;
         sw_s1_q  <= SW;
         sw_s2_q  <= sw_s1_q;
      end
   end

   // The counter only runs while a level change is pending; any return to the
   // accepted level restarts the qualification window.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         deb_q     <= 1'b1;
         deb_cnt_q <= '0;
      end else if (key_s2_q == deb_q) begin
         deb_cnt_q <= '0;
      end else if (deb_cnt_q == CNT_LAST) begin
         deb_q     <= key_s2_q;
         deb_cnt_q <= '0;
      end else begin
         deb_cnt_q <= deb_cnt_q + CNT_W'(1);
      end
   end

   assign press_w = deb_q && !key_s2_q && (deb_cnt_q == CNT_LAST);
   assign legal_w = (sw_s2_q[2:0] <= 3'd5) && (sw_s2_q[4:3] != 2'b11);
   assign full_w  = (cnt_q == DEPTH_V);
   assign push_w  = press_w && legal_w && (!full_w || pop_w);

   always_ff @(posedge CLOCK_50) begin
      if (push_w) mem_q[wr_ptr_q] <= sw_s2_q;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_w) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_w)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_w, pop_w})
            2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         err_illegal_q  <= 1'b0;
         err_overflow_q <= 1'b0;
      end else if (press_w) begin
         if (!legal_w) begin
            err_illegal_q <= 1'b1;
         end else begin
            err_illegal_q <= 1'b0;
            if (full_w && !pop_w) err_overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
      hold_q <= hold_d;
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      pop_w      = 1'b0;
      code_valid = 1'b0;
      code_out   = 4'hF;
      case (state_q)
         S_IDLE: begin
            if (cnt_q != '0) begin
               pop_w   = 1'b1;
               hold_d  = mem_q[rd_ptr_q];
               state_d = S_FACE;
            end
         end
         S_FACE: begin
            code_valid = 1'b1;
            code_out   = {1'b0, hold_q[2:0]};
            if (code_ready) state_d = S_MOD;
         end
         S_MOD: begin
            code_valid = 1'b1;
            case (hold_q[4:3])
               2'b00:   code_out = 4'hB;
               2'b01:   code_out = 4'hC;
               default: code_out = 4'hD;
            endcase
            // Chain straight into the next move so back-to-back moves leave no bubble.
            if (code_ready) begin
               if (cnt_q != '0) begin
                  pop_w   = 1'b1;
                  hold_d  = mem_q[rd_ptr_q];
                  state_d = S_FACE;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign fifo_count   = cnt_q;
   assign err_illegal  = err_illegal_q;
   assign err_overflow = err_overflow_q;

endmodule
